// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared FSM state encodings and NOP encoding for the hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_WAIT     = 2'd2
    } state_e;

    // Instruction loaded into a pipeline register when it is flushed (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_lu_detect.sv
// rtl/hazard_lu_detect.sv - combinational load-use hazard comparator
module hazard_lu_detect #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_mem_read,
    output logic              load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 never carries a real dependency, so a load targeting it cannot cause a stall
    always_comb begin
        rs1_hit  = id_rs1_used && (id_rs1 == id_ex_rd);
        rs2_hit  = id_rs2_used && (id_rs2 == id_ex_rd);
        load_use = id_ex_mem_read && (id_ex_rd != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller (stall/flush FSM, watchdog, optional perf counters under HAZ_CTRL_PERF_EN)
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int BR_FLUSH_CYC = 1,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              dmem_busy,
    output logic              pc_en,
    output logic              pc_sel,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_flush,
    output logic              ex_mem_en,
    output logic              timeout_err,
    output logic [1:0]        state_o,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
);

    localparam int WD_W = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WAIT_TIMEOUT);

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
    logic            load_use;

    hazard_lu_detect #(
        .REG_AW (REG_AW)
    ) u_lu_detect (
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .id_ex_rd       (id_ex_rd),
        .id_ex_mem_read (id_ex_mem_read),
        .load_use       (load_use)
    );

    // Mealy control: WAIT with dmem_busy low behaves exactly like RUN, so both share one arm
    always_comb begin
        pc_en       = 1'b1;
        pc_sel      = 1'b0;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        state_d     = state_q;
        cnt_d       = cnt_q;
        if (rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_en    = 1'b0;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b0;
            state_d     = ST_RUN;
            cnt_d       = 2'd0;
        end else begin
            case (state_q)
                ST_RUN, ST_WAIT: begin
                    if (dmem_busy) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_mem_en = 1'b0;
                        state_d   = ST_WAIT;
                    end else if (ex_branch_taken) begin
                        pc_sel      = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (BR_FLUSH_CYC > 0) begin
                            state_d = ST_REDIRECT;
                            cnt_d   = 2'(BR_FLUSH_CYC);
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        state_d     = ST_RUN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_REDIRECT: begin
                    if (dmem_busy) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_mem_en = 1'b0;
                    end else begin
                        if_id_flush = 1'b1;
                        cnt_d       = cnt_q - 2'd1;
                        // A zero count can only come from corruption; treat it like the last cycle
                        if (cnt_q <= 2'd1) begin
                            state_d = ST_RUN;
                            cnt_d   = 2'd0;
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    // Watchdog: count consecutive busy cycles, saturate, and latch the error until reset
    always_comb begin
        wd_d      = '0;
        timeout_d = timeout_q;
        if (dmem_busy) begin
            wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
        end
        if (wd_d == WD_MAX) begin
            timeout_d = 1'b1;
        end
    end

    // State, redirect counter and watchdog registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= 2'd0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign state_o     = state_q;
    assign timeout_err = timeout_q;

`ifdef HAZ_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // A load-use bubble is the only non-reset case with if_id_en low and id_ex_flush high
    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'((!if_id_en && id_ex_flush) || dmem_busy);
        flush_cnt_d = flush_cnt_q + 32'(if_id_flush);
    end

    // Free-running performance counters, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam logic [6:0] C_RUN   = 7'b1010101;
    localparam logic [6:0] C_RST   = 7'b0001010;
    localparam logic [6:0] C_LU    = 7'b0000111;
    localparam logic [6:0] C_BR    = 7'b1111111;
    localparam logic [6:0] C_REDIR = 7'b1011101;
    localparam logic [6:0] C_FRZ   = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, id_ex_rd;
    logic        id_rs1_used, id_rs2_used, id_ex_mem_read;
    logic        ex_branch_taken, dmem_busy;
    logic        pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
    logic        timeout_err;
    logic [1:0]  state_o;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
    logic [6:0]  ctl;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en};

    hazard_ctrl #(
        .REG_AW       (5),
        .BR_FLUSH_CYC (1),
        .WAIT_TIMEOUT (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_ex_rd        (id_ex_rd),
        .id_ex_mem_read  (id_ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .dmem_busy       (dmem_busy),
        .pc_en           (pc_en),
        .pc_sel          (pc_sel),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_en        (id_ex_en),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_en       (ex_mem_en),
        .timeout_err     (timeout_err),
        .state_o         (state_o),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
    );

    task automatic idle();
        rst             = 1'b0;
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        id_rs1_used     = 1'b0;
        id_rs2_used     = 1'b0;
        id_ex_rd        = 5'd0;
        id_ex_mem_read  = 1'b0;
        ex_branch_taken = 1'b0;
        dmem_busy       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ctl !== C_RST) begin n_fail++; $display("FAIL reset_ctl got %b exp %b", ctl, C_RST); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({ctl, state_o, timeout_err} !== {C_RUN, 2'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_after got ctl=%b st=%0d to=%b exp ctl=%b st=0 to=0", ctl, state_o, timeout_err, C_RUN);
        end
        n_tests++;
        if ({perf_stall_cnt, perf_flush_cnt} !== 64'd0) begin
            n_fail++; $display("FAIL reset_perf got %0d/%0d exp 0/0", perf_stall_cnt, perf_flush_cnt);
        end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({ctl, state_o} !== {C_LU, 2'd0}) begin n_fail++; $display("FAIL lu_rs1 got ctl=%b st=%0d exp ctl=%b st=0", ctl, state_o, C_LU); end
        tick();
        id_ex_mem_read = 1'b0; id_ex_rd = 5'd0;
        @(negedge clk);
        n_tests++;
        if ({ctl, state_o} !== {C_RUN, 2'd0}) begin n_fail++; $display("FAIL lu_bubble got ctl=%b st=%0d exp ctl=%b st=0", ctl, state_o, C_RUN); end
        tick();
        idle();
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; id_rs1 = 5'd3; id_rs1_used = 1'b1; id_rs2 = 5'd7; id_rs2_used = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rs2 got %b exp %b", ctl, C_LU); end
        id_rs2_used = 1'b0;
        #1;
        n_tests++;
        if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_rs2_unused got %b exp %b", ctl, C_RUN); end
        tick();
        idle();
    endtask

    task automatic test_rd_zero();
        idle();
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ctl !== C_RUN) begin n_fail++; $display("FAIL rd_zero got %b exp %b", ctl, C_RUN); end
        tick();
        idle();
    endtask

    task automatic test_branch();
        idle();
        ex_branch_taken = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({ctl, state_o} !== {C_BR, 2'd0}) begin n_fail++; $display("FAIL br_t0 got ctl=%b st=%0d exp ctl=%b st=0", ctl, state_o, C_BR); end
        tick();
        ex_branch_taken = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({ctl, state_o} !== {C_REDIR, 2'd1}) begin n_fail++; $display("FAIL br_t1 got ctl=%b st=%0d exp ctl=%b st=1", ctl, state_o, C_REDIR); end
        tick();
        @(negedge clk);
        n_tests++;
        if ({ctl, state_o} !== {C_RUN, 2'd0}) begin n_fail++; $display("FAIL br_t2 got ctl=%b st=%0d exp ctl=%b st=0", ctl, state_o, C_RUN); end
        tick();
    endtask

    task automatic test_busy_branch();
        logic [1:0] exp_st;
        idle();
        dmem_busy = 1'b1; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_st = (i == 0) ? 2'd0 : 2'd2;
            @(negedge clk);
            n_tests++;
            if ({ctl, state_o} !== {C_FRZ, exp_st}) begin
                n_fail++; $display("FAIL busy_frz%0d got ctl=%b st=%0d exp ctl=%b st=%0d", i, ctl, state_o, C_FRZ, exp_st);
            end
            tick();
        end
        dmem_busy = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({ctl, state_o} !== {C_BR, 2'd2}) begin n_fail++; $display("FAIL busy_release got ctl=%b st=%0d exp ctl=%b st=2", ctl, state_o, C_BR); end
        tick();
        ex_branch_taken = 1'b0;
        dmem_busy = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({ctl, state_o} !== {C_FRZ, 2'd1}) begin n_fail++; $display("FAIL redir_busy got ctl=%b st=%0d exp ctl=%b st=1", ctl, state_o, C_FRZ); end
        tick();
        dmem_busy = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({ctl, state_o} !== {C_REDIR, 2'd1}) begin n_fail++; $display("FAIL redir_hold got ctl=%b st=%0d exp ctl=%b st=1", ctl, state_o, C_REDIR); end
        tick();
        @(negedge clk);
        n_tests++;
        if ({ctl, state_o} !== {C_RUN, 2'd0}) begin n_fail++; $display("FAIL redir_exit got ctl=%b st=%0d exp ctl=%b st=0", ctl, state_o, C_RUN); end
        tick();
    endtask

    task automatic test_watchdog();
        logic exp_to;
        idle();
        dmem_busy = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            exp_to = (i >= 5);
            @(negedge clk);
            n_tests++;
            if (timeout_err !== exp_to) begin n_fail++; $display("FAIL wd_busy%0d got %b exp %b", i, timeout_err, exp_to); end
            tick();
        end
        dmem_busy = 1'b0;
        tick();
        @(negedge clk);
        n_tests++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL wd_sticky got %b exp 1", timeout_err); end
        do_reset();
        @(negedge clk);
        n_tests++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL wd_rst got %b exp 0", timeout_err); end
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ctl !== C_RST) begin n_fail++; $display("FAIL rst_redir_ctl got %b exp %b", ctl, C_RST); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({ctl, state_o} !== {C_RUN, 2'd0}) begin n_fail++; $display("FAIL rst_redir_after got ctl=%b st=%0d exp ctl=%b st=0", ctl, state_o, C_RUN); end
        tick();
        dmem_busy = 1'b1;
        tick();
        dmem_busy = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({ctl, state_o} !== {C_RUN, 2'd0}) begin n_fail++; $display("FAIL rst_wait_after got ctl=%b st=%0d exp ctl=%b st=0", ctl, state_o, C_RUN); end
        tick();
    endtask

    task automatic test_perf();
        logic [31:0] exp_stall, exp_flush;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            idle();
            id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
            tick();
            idle();
            tick();
        end
        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0;
        tick();
        tick();
`ifdef HAZ_CTRL_PERF_EN
        exp_stall = 32'd2;
        exp_flush = 32'd2;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        @(negedge clk);
        n_tests++;
        if (perf_stall_cnt !== exp_stall) begin n_fail++; $display("FAIL perf_stall got %0d exp %0d", perf_stall_cnt, exp_stall); end
        n_tests++;
        if (perf_flush_cnt !== exp_flush) begin n_fail++; $display("FAIL perf_flush got %0d exp %0d", perf_flush_cnt, exp_flush); end
        tick();
    endtask

    initial begin
        idle();
        tick();
        test_reset();
        test_load_use();
        test_rd_zero();
        test_branch();
        test_busy_branch();
        test_watchdog();
        test_reset_mid();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
